// File: rtl/if_pc_fetch_ctrl.sv
// if_pc_fetch_ctrl: IF-stage PC holder issuing one-outstanding fetches into a stall-absorbing IF/ID slot.
module if_pc_fetch_ctrl #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_ID,
    input  logic [DATA_W-1:0] PC_jump_jalr,
    input  logic              flush_jalr,
    output logic              im_req,
    output logic [DATA_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic              im_rvalid,
    input  logic [DATA_W-1:0] im_rdata,
    output logic [DATA_W-1:0] PC_ID,
    output logic [DATA_W-1:0] inst_ID,
    output logic              valid_ID,
    output logic              misalign_jalr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] pc, pc_nx, kill_addr, rsp_pc, hold_pc, hold_inst;
    logic              hold_valid, hold_nx, kill_pend, kill_nx;
    logic              hs, deliver, to_slot, to_hold;

    assign hs      = im_req & im_ready;
    assign deliver = state == WAIT && im_rvalid && !kill_pend && !flush_jalr;
    assign to_slot = deliver && (!valid_ID || !stall_ID);
    assign to_hold = deliver && valid_ID && stall_ID;
    assign hold_nx = flush_jalr ? 1'b0 : to_hold ? 1'b1 : (hold_valid && !stall_ID) ? 1'b0 : hold_valid;

    // A request killed before acceptance stays on the bus at its old address
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        kill_nx  = kill_pend;
        im_req   = state == REQ;
        im_addr  = kill_pend ? kill_addr : pc;
        case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                state_nx = hs ? WAIT : REQ;
                pc_nx    = (hs && !kill_pend) ? pc + DATA_W'(4) : pc;
            end
            WAIT: begin
                kill_nx  = im_rvalid ? 1'b0 : kill_pend;
                state_nx = !im_rvalid ? WAIT : hold_nx ? FULL : REQ;
            end
            default: state_nx = hold_nx ? FULL : REQ;
        endcase
        if (flush_jalr) begin
            pc_nx   = PC_jump_jalr & ~DATA_W'(3);
            kill_nx = (state == REQ || (state == WAIT && !im_rvalid)) ? 1'b1 : kill_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            kill_pend     <= 1'b0;
            kill_addr     <= '0;
            rsp_pc        <= '0;
            hold_valid    <= 1'b0;
            hold_pc       <= '0;
            hold_inst     <= '0;
            PC_ID         <= '0;
            inst_ID       <= '0;
            valid_ID      <= 1'b0;
            misalign_jalr <= 1'b0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            kill_pend     <= kill_nx;
            kill_addr     <= im_addr;
            hold_valid    <= hold_nx;
            misalign_jalr <= flush_jalr & PC_jump_jalr[1];
            if (hs)
                rsp_pc <= im_addr;
            if (to_hold) begin
                hold_pc   <= rsp_pc;
                hold_inst <= im_rdata;
            end
            if (flush_jalr)
                valid_ID <= 1'b0;
            else if (to_slot) begin
                PC_ID    <= rsp_pc;
                inst_ID  <= im_rdata;
                valid_ID <= 1'b1;
            end else if (!stall_ID) begin
                valid_ID <= hold_valid;
                if (hold_valid) begin
                    PC_ID   <= hold_pc;
                    inst_ID <= hold_inst;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_pc_fetch_ctrl.sv
// tb_if_pc_fetch_ctrl: vector table plus redirect/reset sequences, instruction delivery checked by a scoreboard.
module tb_if_pc_fetch_ctrl;
    logic        clk = 0, rst_n = 0, stall_ID = 0, flush_jalr = 0, im_ready = 1, im_rvalid = 0;
    logic [31:0] PC_jump_jalr = 0, im_rdata = 0;
    logic [31:0] im_addr, PC_ID, inst_ID;
    logic        im_req, valid_ID, misalign_jalr;

    int checks = 0, failures = 0;

    typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
    exp_t q[$];

    typedef struct {logic ready; logic stall; logic req; logic [31:0] addr; logic vld; logic [31:0] pc;} vec_t;
    vec_t tbl[14];

    int          lat = 1, cnt = 0;
    logic [31:0] rsp_addr = 0, hs_addr = 0, prev_addr = 0;
    bit          hs = 0, hs_killed = 0, rsp_killed = 0, next_killed = 0, prev_stuck = 0;

    if_pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall_ID(stall_ID), .PC_jump_jalr(PC_jump_jalr),
        .flush_jalr(flush_jalr), .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .PC_ID(PC_ID), .inst_ID(inst_ID),
        .valid_ID(valid_ID), .misalign_jalr(misalign_jalr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h8 ? 32'h00A00093 : a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t v(input logic r, input logic s, input logic rq, input logic [31:0] a,
                               input logic d, input logic [31:0] p);
        vec_t t;
        t.ready = r; t.stall = s; t.req = rq; t.addr = a; t.vld = d; t.pc = p;
        return t;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Observe one cycle just before the active edge: ID consumption, responses, redirect effects
    task automatic sample();
        @(negedge clk);
        hs = 0;
        if (!rst_n) begin
            prev_stuck = 0;
            return;
        end
        if (prev_stuck) begin
            chk1("stuck_req_held", im_req, 1'b1);
            chk32("stuck_addr_stable", im_addr, prev_addr);
        end
        if (valid_ID && !stall_ID) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got PC_ID 0x%08h expected no instruction", PC_ID);
            end else begin
                exp_t e = q.pop_front();
                chk32("sb_pc", PC_ID, e.pc);
                chk32("sb_inst", inst_ID, e.inst);
            end
        end
        if (im_rvalid && !rsp_killed && !flush_jalr)
            q.push_back('{rsp_addr, mem_word(rsp_addr)});
        hs        = im_req && im_ready;
        hs_addr   = im_addr;
        hs_killed = next_killed || flush_jalr;
        if (flush_jalr) begin
            q.delete();
            if (im_req && !im_ready) next_killed = 1;
            if (cnt > 0) rsp_killed = 1;
        end
        prev_stuck = im_req && !im_ready;
        prev_addr  = im_addr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        im_rvalid = 0;
        if (hs) begin
            cnt         = lat;
            rsp_addr    = hs_addr;
            rsp_killed  = hs_killed;
            next_killed = 0;
        end
        hs = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                im_rvalid = 1;
                im_rdata  = mem_word(rsp_addr);
            end
        end
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20; i++) begin
            sample();
            if (im_req) return;
            advance();
        end
        checks++;
        failures++;
        $display("FAIL %s: got no im_req expected im_req within 20 cycles", name);
    endtask

    initial begin
        tbl[0]  = v(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[1]  = v(1, 0, 1, 32'h0,  0, 32'h0);
        tbl[2]  = v(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[3]  = v(1, 0, 1, 32'h4,  1, 32'h0);
        tbl[4]  = v(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[5]  = v(1, 0, 1, 32'h8,  1, 32'h4);
        tbl[6]  = v(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[7]  = v(0, 0, 1, 32'hC,  1, 32'h8);
        tbl[8]  = v(1, 0, 1, 32'hC,  0, 32'h0);
        tbl[9]  = v(1, 0, 0, 32'h0,  0, 32'h0);
        tbl[10] = v(1, 1, 1, 32'h10, 1, 32'hC);
        tbl[11] = v(1, 1, 0, 32'h0,  1, 32'hC);
        tbl[12] = v(1, 0, 0, 32'h0,  1, 32'hC);
        tbl[13] = v(1, 0, 1, 32'h14, 1, 32'h10);

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", im_req, 1'b0);
        chk32("rst_addr", im_addr, 32'h0);
        chk1("rst_valid", valid_ID, 1'b0);
        chk32("rst_pc_id", PC_ID, 32'h0);
        chk32("rst_inst_id", inst_ID, 32'h0);
        chk1("rst_misalign", misalign_jalr, 1'b0);
        rst_n = 1;

        for (int k = 0; k < 14; k++) begin
            im_ready = tbl[k].ready;
            stall_ID = tbl[k].stall;
            sample();
            chk1($sformatf("tbl%0d_req", k), im_req, tbl[k].req);
            if (tbl[k].req) chk32($sformatf("tbl%0d_addr", k), im_addr, tbl[k].addr);
            chk1($sformatf("tbl%0d_valid", k), valid_ID, tbl[k].vld);
            if (tbl[k].vld) chk32($sformatf("tbl%0d_pc_id", k), PC_ID, tbl[k].pc);
            advance();
        end

        // Redirect while a slow response is outstanding
        wait_req("t3_pre");
        lat = 3;
        advance();
        flush_jalr = 1; PC_jump_jalr = 32'h0000_0101; im_ready = 0;
        sample();
        advance();
        flush_jalr = 0;
        sample();
        chk1("t3_misalign", misalign_jalr, 1'b0);
        chk1("t3_valid_gap", valid_ID, 1'b0);
        advance();
        wait_req("t3_req");
        chk32("t3_addr", im_addr, 32'h100);
        chk1("t3_valid", valid_ID, 1'b0);
        advance();

        // Redirect while the request is stuck waiting for im_ready
        flush_jalr = 1; PC_jump_jalr = 32'h0000_0202;
        sample();
        chk32("t4_addr_flush", im_addr, 32'h100);
        advance();
        flush_jalr = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk32("t4_addr_hold", im_addr, 32'h100);
            chk1("t4_misalign", misalign_jalr, i == 0);
            advance();
        end
        lat = 1; im_ready = 1;
        sample();
        advance();
        wait_req("t4_req");
        chk32("t4_addr", im_addr, 32'h200);
        advance();

        // Redirect coinciding with a response while ID is stalled
        sample();
        advance();
        stall_ID = 1;
        sample();
        chk1("t5_valid_pre", valid_ID, 1'b1);
        chk32("t5_pc_pre", PC_ID, 32'h200);
        chk32("t5_addr_pre", im_addr, 32'h204);
        advance();
        flush_jalr = 1; PC_jump_jalr = 32'h0000_0300;
        sample();
        advance();
        flush_jalr = 0;
        sample();
        chk1("t5_valid", valid_ID, 1'b0);
        chk1("t5_req", im_req, 1'b1);
        chk32("t5_addr", im_addr, 32'h300);
        advance();

        // PC wrap at the top of the address space, then reset in WAIT
        stall_ID = 0; flush_jalr = 1; PC_jump_jalr = 32'hFFFF_FFFC;
        sample();
        advance();
        flush_jalr = 0;
        sample();
        chk1("t6_req_top", im_req, 1'b1);
        chk32("t6_addr_top", im_addr, 32'hFFFF_FFFC);
        advance();
        stall_ID = 1;
        sample();
        advance();
        sample();
        chk32("t6_addr_wrap", im_addr, 32'h0);
        chk1("t6_valid", valid_ID, 1'b1);
        chk32("t6_pc_id", PC_ID, 32'hFFFF_FFFC);
        lat = 3;
        advance();
        rst_n = 0;
        q.delete(); rsp_killed = 1; next_killed = 0; prev_stuck = 0;
        #1;
        chk1("t6_rst_req", im_req, 1'b0);
        chk1("t6_rst_valid", valid_ID, 1'b0);
        chk32("t6_rst_pc_id", PC_ID, 32'h0);
        chk32("t6_rst_inst_id", inst_ID, 32'h0);
        chk1("t6_rst_misalign", misalign_jalr, 1'b0);
        advance();
        advance();
        rst_n = 1; stall_ID = 0;
        sample();
        chk1("t6_rel_idle", im_req, 1'b0);
        advance();
        sample();
        chk1("t6_rel_req", im_req, 1'b1);
        chk32("t6_rel_addr", im_addr, 32'h0);
        lat = 1;
        advance();
        im_ready = 0;
        repeat (8) begin
            sample();
            advance();
        end
        chk32("sb_drained", q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
